// File: rtl/if_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : if_fetch_pkg
// Purpose : Shared definitions for the instruction-fetch stage.
//           Contents: opcode constants, bus widths, FSM state encodings,
//           and the static next-PC predictor function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] IF_FETCH = 1'b0;
  localparam logic [0:0] IF_HOLD  = 1'b1;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] npc;
    logic                   taken;
  } pred_t;

  // JAL is always taken. A conditional branch is predicted taken only when
  // its offset is negative (inst[31] is the immediate sign bit).
  // JALR has a register-based target, so it always falls through to pc+4.
  function automatic pred_t predict(input logic [INST_ADDR_W-1:0] pc,
                                    input logic [INST_W-1:0]      inst);
    pred_t       p;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    imm_j   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_b   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    p.npc   = pc + 32'd4;
    p.taken = 1'b0;
    if (inst[6:0] == OP_JAL) begin
      p.npc   = pc + imm_j;
      p.taken = 1'b1;
    end else if ((inst[6:0] == OP_BRANCH) && inst[31]) begin
      p.npc   = pc + imm_b;
      p.taken = 1'b1;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_icache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : if_icache
// Purpose : Direct-mapped instruction cache, one 32-bit instruction per line.
//           Only built when IF_ICACHE_EN is defined.
// Ports   : clk_i, rst_i (async, active-high; clears valid bits only)
//           lookup_addr_i -> hit_o, data_o   (combinational lookup)
//           fill_addr_i, fill_data_i, fill_we_i (line write)
// Revision: 1.0 - initial release
// ============================================================================
module if_icache #(
  parameter int LINES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_addr_i,
  output logic        hit_o,
  output logic [31:0] data_o,
  input  logic [31:0] fill_addr_i,
  input  logic [31:0] fill_data_i,
  input  logic        fill_we_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_fl_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_fl_tag;
  logic             w_unused_lsb;

  assign w_lk_idx     = lookup_addr_i[IDX_W+1:2];
  assign w_lk_tag     = lookup_addr_i[31:IDX_W+2];
  assign w_fl_idx     = fill_addr_i[IDX_W+1:2];
  assign w_fl_tag     = fill_addr_i[31:IDX_W+2];
  // Instructions are word aligned; the byte offset never selects anything.
  assign w_unused_lsb = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  assign hit_o  = valid_q[w_lk_idx] & (tag_q[w_lk_idx] == w_lk_tag);
  assign data_o = data_q[w_lk_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_we_i) begin
      valid_q[w_fl_idx] <= 1'b1;
    end
  end

  // Tag/data storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[w_fl_idx]  <= w_fl_tag;
      data_q[w_fl_idx] <= fill_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : if_fetch
// Purpose : RV32I instruction-fetch stage. Reads 4 bytes little-endian over a
//           byte-wide shared memory port, assembles the instruction, predicts
//           the next PC statically and holds the result until ID accepts it.
//           Optional macro IF_ICACHE_EN adds a direct-mapped icache.
// Ports   : clk_in, rst_in (async, active-high)
//           mem_req_out/mem_addr_out/mem_gnt_in/mem_data_in : byte memory port
//           flush_in/flush_pc_in : redirect from EX
//           id_ready_in : ID accepts (0 = stall)
//           valid_out/pc_out/inst_out/pre_to_take_out : stream to ID
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic                   mem_req_out,
  output logic [INST_ADDR_W-1:0] mem_addr_out,
  input  logic                   mem_gnt_in,
  input  logic [7:0]             mem_data_in,
  input  logic                   flush_in,
  input  logic [INST_ADDR_W-1:0] flush_pc_in,
  input  logic                   id_ready_in,
  output logic                   valid_out,
  output logic [INST_ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0]      inst_out,
  output logic                   pre_to_take_out
);

  logic [0:0]  state_q, state_d;
  logic [31:0] fpc_q;
  logic [31:0] npc_q;
  logic [2:0]  ic_q;
  logic [2:0]  rc_q;
  logic [23:0] buf_q;
  logic        rx_q;
  logic        drop_q;
  logic        valid_q;
  logic        taken_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  logic        w_in_fetch;
  logic        w_rx;
  logic        w_last;
  logic        w_hit;
  logic        w_req;
  logic        w_grant;
  logic        w_xfer;
  logic [31:0] w_asm;
  logic [31:0] w_new_inst;
  pred_t       w_pred;

  assign w_in_fetch = (state_q == IF_FETCH);
  // A byte granted just before a redirect belongs to the old stream.
  assign w_rx       = rx_q & ~drop_q;
  // Final byte is taken straight off the bus so HOLD starts the same edge.
  assign w_asm      = {mem_data_in, buf_q};
  assign w_last     = w_in_fetch & w_rx & (rc_q == 3'd3);
  assign w_xfer     = valid_q & id_ready_in;

`ifdef IF_ICACHE_EN
  logic        w_lookup_hit;
  logic [31:0] w_cache_data;

  if_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .lookup_addr_i (fpc_q),
    .hit_o         (w_lookup_hit),
    .data_o        (w_cache_data),
    .fill_addr_i   (fpc_q),
    .fill_data_i   (w_asm),
    .fill_we_i     (w_last)
  );

  // Lookup only before any byte of this PC has been requested.
  assign w_hit      = w_in_fetch & (ic_q == 3'd0) & (rc_q == 3'd0)
                      & w_lookup_hit & ~flush_in;
  assign w_new_inst = w_hit ? w_cache_data : w_asm;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ICACHE_LINES[0];
  assign w_hit        = 1'b0;
  assign w_new_inst   = w_asm;
`endif

  assign w_req   = ~rst_in & w_in_fetch & (ic_q < 3'd4) & ~flush_in & ~w_hit;
  assign w_grant = w_req & mem_gnt_in;
  assign w_pred  = predict(fpc_q, w_new_inst);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IF_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = IF_FETCH;
    end else begin
      case (state_q)
        IF_FETCH: if (w_last || w_hit) state_d = IF_HOLD;
        IF_HOLD:  if (w_xfer)          state_d = IF_FETCH;
        default:                       state_d = IF_FETCH;
      endcase
    end
  end

  // Output logic (memory request side)
  always_comb begin
    mem_req_out  = w_req;
    mem_addr_out = 32'h0;
    if (w_req) begin
      mem_addr_out = fpc_q + {29'd0, ic_q};
    end
  end

  // Datapath
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fpc_q   <= RESET_PC;
      npc_q   <= '0;
      ic_q    <= '0;
      rc_q    <= '0;
      buf_q   <= '0;
      rx_q    <= 1'b0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      rx_q   <= w_grant;
      drop_q <= flush_in;
      if (flush_in) begin
        // A transfer in this same cycle still counts as consumed by ID.
        fpc_q   <= flush_pc_in;
        valid_q <= 1'b0;
        ic_q    <= '0;
        rc_q    <= '0;
      end else if (w_in_fetch) begin
        if (w_grant) begin
          ic_q <= ic_q + 3'd1;
        end
        if (w_rx) begin
          rc_q <= rc_q + 3'd1;
          case (rc_q)
            3'd0:    buf_q[7:0]   <= mem_data_in;
            3'd1:    buf_q[15:8]  <= mem_data_in;
            3'd2:    buf_q[23:16] <= mem_data_in;
            default: ;
          endcase
        end
        if (w_last || w_hit) begin
          valid_q <= 1'b1;
          pc_q    <= fpc_q;
          inst_q  <= w_new_inst;
          npc_q   <= w_pred.npc;
          taken_q <= w_pred.taken;
        end
      end else if (w_xfer) begin
        valid_q <= 1'b0;
        fpc_q   <= npc_q;
        ic_q    <= '0;
        rc_q    <= '0;
      end
    end
  end

  assign valid_out       = valid_q;
  assign pc_out          = pc_q;
  assign inst_out        = inst_q;
  assign pre_to_take_out = taken_q;

endmodule
`default_nettype wire
